// File: rtl/spu_pipe_pkg.sv
// spu_pipe_pkg: shared constants and helpers for the SPU execution pipe.
//
// Packet layout, MSB first:
//   {valid, unit_id, result, spare, reg_dst[6:0], latency[3:0], reg_wr}
// The low control fields sit at fixed offsets. The fields above them move
// with DATA_W and UNIT_W, so the top derives those offsets from its own
// parameters. The constants here describe the default 128-bit / 3-bit packet.
// Bit 12 is a spare bit and is always driven to zero.
package spu_pipe_pkg;

    localparam int SPU_DATA_W = 128;
    localparam int SPU_UNIT_W = 3;

    // Low fields do not depend on any parameter.
    localparam int REGWR_BIT = 0;
    localparam int LAT_LSB   = 1;
    localparam int LAT_MSB   = 4;
    localparam int DST_LSB   = 5;
    localparam int DST_MSB   = 11;
    localparam int SPARE_BIT = 12;
    localparam int RES_LSB   = 13;

    // Upper fields, shown for the default widths.
    localparam int RES_MSB   = RES_LSB + SPU_DATA_W - 1;
    localparam int UNIT_LSB  = RES_MSB + 1;
    localparam int UNIT_MSB  = UNIT_LSB + SPU_UNIT_W - 1;
    localparam int VALID_BIT = UNIT_MSB + 1;
    localparam int PKT_W     = 1 + SPU_UNIT_W + SPU_DATA_W + 13;

    // Unit identifiers.
    localparam logic [SPU_UNIT_W-1:0] FX1  = 3'd0;
    localparam logic [SPU_UNIT_W-1:0] FX2  = 3'd1;
    localparam logic [SPU_UNIT_W-1:0] SP   = 3'd2;
    localparam logic [SPU_UNIT_W-1:0] BYTE = 3'd3;

    // Latency is stored clamped to 1..max_lat.
    // A latency of 0 still needs one stage before the result can be forwarded.
    function automatic logic [3:0] clamp_latency(input logic [3:0] lat,
                                                 input logic [3:0] max_lat);
        logic [3:0] r;
        r = lat;
        if (lat == 4'd0) begin
            r = 4'd1;
        end else if (lat > max_lat) begin
            r = max_lat;
        end
        return r;
    endfunction

endpackage

// File: rtl/spu_pipe_stage.sv
// spu_pipe_stage: one packet register of the execution pipe.
//
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   hold     : keep the current packet (stall)
//   kill     : clear the valid bit (MSB)
//              - when hold=1, the packet held in place loses its valid bit
//              - when hold=0, the incoming packet is stored with valid=0
//   d        : incoming packet
//   q        : registered packet
// Only the valid bit is touched on a kill. The data fields are kept.
module spu_pipe_stage #(
    parameter int PKT_W = 145
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             kill,
    input  logic [PKT_W-1:0] d,
    output logic [PKT_W-1:0] q
);

    logic [PKT_W-1:0] pkt_d;
    logic [PKT_W-1:0] pkt_q;

    always_comb begin
        pkt_d = hold ? pkt_q : d;
        if (kill) begin
            pkt_d[PKT_W-1] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    assign q = pkt_q;

endmodule

// File: rtl/spu_exec_pipe.sv
// spu_exec_pipe: execution-pipe backbone for the SPU even and odd pipes.
//
// How a packet moves through the pipe:
//   - The issuing unit's result is selected and packed into a packet.
//   - The packet is carried through NUM_STAGES registered stages.
//   - Every stage is exposed to the forwarding unit.
//   - The last stage drives a registered register-file writeback.
//
// Ports:
//   clk, rst        : clock and asynchronous active-high reset
//   issue_*         : issue-side packet fields
//                     (valid, unit id, dst, latency, reg_wr)
//   unit_results    : all unit outputs; unit 0 is in the MSBs
//   stall           : freeze every stage and suppress writeback
//   flush           : invalidate the FLUSH_DEPTH youngest stages
//   fwd_pkts        : all stage packets; stage 1 is in the MSBs
//   fwd_ready[k-1]  : stage k holds a valid packet whose latency is <= k
//   wb_addr/data/en : registered writeback
//
// Handshake: there is no ready path in either direction.
//   - An issue is taken on any clock edge with issue_valid=1 and stall=0.
//   - While stall=1 the issuer keeps the issue_* inputs stable.
//   - The register file accepts every wb_en pulse.
module spu_exec_pipe
    import spu_pipe_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int NUM_UNITS   = 4,
    parameter int UNIT_W      = 3,
    parameter int NUM_STAGES  = 7,
    parameter int FLUSH_DEPTH = 1,
    localparam int PKT_LEN    = 1 + UNIT_W + DATA_W + 13
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid,
    input  logic [UNIT_W-1:0]               issue_unit_id,
    input  logic [NUM_UNITS*DATA_W-1:0]     unit_results,
    input  logic [6:0]                      issue_reg_dst,
    input  logic [3:0]                      issue_latency,
    input  logic                            issue_reg_wr,
    input  logic                            stall,
    input  logic                            flush,
    output logic [NUM_STAGES*PKT_LEN-1:0]   fwd_pkts,
    output logic [NUM_STAGES-1:0]           fwd_ready,
    output logic [6:0]                      wb_addr,
    output logic [DATA_W-1:0]               wb_data,
    output logic                            wb_en
);

    // Offsets of the upper fields for this instance's widths.
    localparam int R_MSB = RES_LSB + DATA_W - 1;
    localparam int U_LSB = R_MSB + 1;
    localparam int U_MSB = U_LSB + UNIT_W - 1;
    localparam int V_BIT = U_MSB + 1;

    logic [DATA_W-1:0]  res0;
    logic [PKT_LEN-1:0] pkt0;
    logic [PKT_LEN-1:0] stage_pkt [1:NUM_STAGES];

    // Stage 0: combinational packet build.
    // An out-of-range unit id selects no slice, so the result is zero.
    always_comb begin
        res0 = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (issue_unit_id == UNIT_W'(u)) begin
                res0 = unit_results[(NUM_UNITS-1-u)*DATA_W +: DATA_W];
            end
        end
        pkt0                    = '0;
        pkt0[V_BIT]             = issue_valid;
        pkt0[U_MSB:U_LSB]       = issue_unit_id;
        pkt0[R_MSB:RES_LSB]     = res0;
        pkt0[DST_MSB:DST_LSB]   = issue_reg_dst;
        pkt0[LAT_MSB:LAT_LSB]   = clamp_latency(issue_latency, 4'(NUM_STAGES));
        pkt0[REGWR_BIT]         = issue_reg_wr;
    end

    for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stage
        localparam bit KILLABLE = (k <= FLUSH_DEPTH);
        logic [PKT_LEN-1:0] d_in;
        logic               kill;

        if (k == 1) begin : g_first
            assign d_in = pkt0;
        end else begin : g_rest
            assign d_in = stage_pkt[k-1];
        end

        assign kill = flush & KILLABLE;

        spu_pipe_stage #(.PKT_W(PKT_LEN)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .hold (stall),
            .kill (kill),
            .d    (d_in),
            .q    (stage_pkt[k])
        );

        assign fwd_pkts[(NUM_STAGES-k)*PKT_LEN +: PKT_LEN] = stage_pkt[k];
        assign fwd_ready[k-1] = stage_pkt[k][V_BIT] &&
                                (stage_pkt[k][LAT_MSB:LAT_LSB] <= 4'(k));
    end

    // Writeback from the last stage.
    // While stalled, the last stage still holds the packet that will be
    // written after release, so wb_en stays low to avoid a double write.
    logic              wb_en_d,   wb_en_q;
    logic [6:0]        wb_addr_d, wb_addr_q;
    logic [DATA_W-1:0] wb_data_d, wb_data_q;

    always_comb begin
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (!stall) begin
            wb_en_d   = stage_pkt[NUM_STAGES][V_BIT] & stage_pkt[NUM_STAGES][REGWR_BIT];
            wb_addr_d = stage_pkt[NUM_STAGES][DST_MSB:DST_LSB];
            wb_data_d = stage_pkt[NUM_STAGES][R_MSB:RES_LSB];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_spu_exec_pipe.sv
// tb_spu_exec_pipe: directed bench for spu_exec_pipe.
// Configuration: NUM_STAGES=7, FLUSH_DEPTH=2.
// Writebacks are checked against an expected queue of {addr, data}.
module tb_spu_exec_pipe;

    localparam int NS = 7;
    localparam int PW = 145;
    localparam int DW = 128;

    localparam logic [DW-1:0] D0 = 128'h12345678_9abcdef0_0fedcba9_87654321;
    localparam logic [DW-1:0] D1 = 128'ha5a5a5a5_11111111_22222222_33333333;
    localparam logic [DW-1:0] D2 = 128'h5a5a5a5a_44444444_55555555_66666666;
    localparam logic [DW-1:0] D3 = 128'hdeadbeef_77777777_88888888_99999999;

    logic              clk;
    logic              rst;
    logic              issue_valid;
    logic [2:0]        issue_unit_id;
    logic [4*DW-1:0]   unit_results;
    logic [6:0]        issue_reg_dst;
    logic [3:0]        issue_latency;
    logic              issue_reg_wr;
    logic              stall;
    logic              flush;
    logic [NS*PW-1:0]  fwd_pkts;
    logic [NS-1:0]     fwd_ready;
    logic [6:0]        wb_addr;
    logic [DW-1:0]     wb_data;
    logic              wb_en;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [134:0] exp_q[$];

    spu_exec_pipe #(.NUM_STAGES(NS), .FLUSH_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_unit_id (issue_unit_id),
        .unit_results  (unit_results),
        .issue_reg_dst (issue_reg_dst),
        .issue_latency (issue_latency),
        .issue_reg_wr  (issue_reg_wr),
        .stall         (stall),
        .flush         (flush),
        .fwd_pkts      (fwd_pkts),
        .fwd_ready     (fwd_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_en         (wb_en)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] stage_of(input int k);
        return fwd_pkts[(NS-k)*PW +: PW];
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] unit, input logic [6:0] dst,
                         input logic [3:0] lat, input logic wr);
        issue_valid   = 1'b1;
        issue_unit_id = unit;
        issue_reg_dst = dst;
        issue_latency = lat;
        issue_reg_wr  = wr;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
    endtask

    task automatic expect_wb(input logic [6:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // scoreboard: every writeback must match the next expected entry
    always @(negedge clk) begin
        logic [134:0] e;
        if (wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_spurious", 160'(wb_en), 160'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_addr", 160'(wb_addr), 160'(e[134:128]));
                chk("wb_data", 160'(wb_data), 160'(e[127:0]));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        issue_valid   = 1'b0;
        issue_unit_id = '0;
        issue_reg_dst = '0;
        issue_latency = '0;
        issue_reg_wr  = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        unit_results  = {D0, D1, D2, D3};
        repeat (3) tick();
        chk("rst_pkts",  160'(|fwd_pkts), 160'd0);
        chk("rst_ready", 160'(fwd_ready), 160'd0);
        chk("rst_wb_en", 160'(wb_en), 160'd0);
        rst = 1'b0;
        tick();

        // T1: single issue, lat=2, check forwarding and writeback timing
        issue(3'd0, 7'd5, 4'd2, 1'b1);
        expect_wb(7'd5, D0);
        tick();                                     // cycle 1
        idle();
        chk("t1_s1_valid", 160'(stage_of(1)[144]), 160'd1);
        chk("t1_ready0_c1", 160'(fwd_ready[0]), 160'd0);
        tick();                                     // cycle 2
        chk("t1_ready1_c2", 160'(fwd_ready[1]), 160'd1);
        chk("t1_ready0_c2", 160'(fwd_ready[0]), 160'd0);
        repeat (5) tick();                          // cycle 7
        chk("t1_wb_en_c7", 160'(wb_en), 160'd0);
        tick();                                     // cycle 8
        chk("t1_wb_en_c8", 160'(wb_en), 160'd1);
        chk("t1_wb_addr", 160'(wb_addr), 160'd5);
        chk("t1_wb_data", 160'(wb_data), 160'(D0));
        tick();                                     // cycle 9
        chk("t1_wb_en_c9", 160'(wb_en), 160'd0);
        repeat (3) tick();

        // T2: back-to-back issues from every unit, then an out-of-range unit
        issue(3'd0, 7'd10, 4'd1, 1'b1); expect_wb(7'd10, D0); tick();
        issue(3'd1, 7'd11, 4'd1, 1'b1); expect_wb(7'd11, D1); tick();
        issue(3'd2, 7'd12, 4'd1, 1'b1); expect_wb(7'd12, D2); tick();
        issue(3'd3, 7'd13, 4'd1, 1'b1); expect_wb(7'd13, D3); tick();
        issue(3'd5, 7'd14, 4'd1, 1'b1); expect_wb(7'd14, '0); tick();
        idle();
        chk("t2_unit5_res", 160'(stage_of(1)[140:13]), 160'd0);
        chk("t2_unit3_res", 160'(stage_of(2)[140:13]), 160'(D3));
        repeat (12) tick();
        chk("t2_drained", 160'(exp_q.size()), 160'd0);

        // T3: stall for 3 cycles while the packet sits in stage 7
        issue(3'd1, 7'd20, 4'd3, 1'b1);
        expect_wb(7'd20, D1);
        tick();
        idle();
        repeat (6) tick();
        chk("t3_s7_valid", 160'(stage_of(7)[144]), 160'd1);
        chk("t3_wb_pre", 160'(wb_en), 160'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_wb_stall", 160'(wb_en), 160'd0);
        end
        chk("t3_s7_held", 160'(stage_of(7)[11:5]), 160'd20);
        stall = 1'b0;
        tick();
        chk("t3_wb_release", 160'(wb_en), 160'd1);
        chk("t3_wb_addr", 160'(wb_addr), 160'd20);
        tick();
        chk("t3_wb_once", 160'(wb_en), 160'd0);
        repeat (3) tick();

        // T4: flush (depth 2) with packets in stages 0..3
        issue(3'd0, 7'd30, 4'd1, 1'b1); expect_wb(7'd30, D0); tick();
        issue(3'd1, 7'd31, 4'd1, 1'b1); expect_wb(7'd31, D1); tick();
        issue(3'd2, 7'd32, 4'd1, 1'b1); tick();
        issue(3'd3, 7'd33, 4'd1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("t4_s1_killed", 160'(stage_of(1)[144]), 160'd0);
        chk("t4_s2_killed", 160'(stage_of(2)[144]), 160'd0);
        chk("t4_s2_dst",    160'(stage_of(2)[11:5]), 160'd32);
        chk("t4_s3_valid",  160'(stage_of(3)[144]), 160'd1);
        chk("t4_s4_valid",  160'(stage_of(4)[144]), 160'd1);
        repeat (12) tick();
        chk("t4_drained", 160'(exp_q.size()), 160'd0);

        // T5: latency clamp (0 -> 1, 12 -> 7); a reg_wr=0 issue never writes
        issue(3'd2, 7'd40, 4'd0, 1'b1);
        expect_wb(7'd40, D2);
        tick();
        chk("t5_lat0_stored", 160'(stage_of(1)[4:1]), 160'd1);
        chk("t5_lat0_ready1", 160'(fwd_ready[0]), 160'd1);
        issue(3'd3, 7'd41, 4'd12, 1'b1);
        expect_wb(7'd41, D3);
        tick();
        idle();
        chk("t5_lat12_stored", 160'(stage_of(1)[4:1]), 160'd7);
        chk("t5_lat12_ready1", 160'(fwd_ready[0]), 160'd0);
        chk("t5_lat0_ready2",  160'(fwd_ready[1]), 160'd1);
        repeat (5) tick();
        chk("t5_lat12_ready6", 160'(fwd_ready[5]), 160'd0);
        tick();
        chk("t5_lat12_ready7", 160'(fwd_ready[6]), 160'd1);
        issue(3'd1, 7'd42, 4'd1, 1'b0);
        tick();
        idle();
        repeat (10) tick();
        chk("t5_drained", 160'(exp_q.size()), 160'd0);

        // T6: asynchronous reset with 5 packets in flight
        for (int i = 0; i < 5; i++) begin
            issue(3'(i % 4), 7'(50 + i), 4'd1, 1'b1);
            tick();
        end
        idle();
        chk("t6_ready_busy", 160'(fwd_ready), 160'h1f);
        rst = 1'b1;
        #1;
        chk("t6_ready_rst", 160'(fwd_ready), 160'd0);
        chk("t6_wb_en_rst", 160'(wb_en), 160'd0);
        chk("t6_pkts_rst",  160'(|fwd_pkts), 160'd0);
        chk("t6_wb_data_rst", 160'(wb_data), 160'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("final_q_empty", 160'(exp_q.size()), 160'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/spu_exec_pipe.md
Name: spu_exec_pipe

Overview:
- Parametrised execution-pipe backbone for SPU even/odd pipes.
- Selects the issuing unit's 128-bit result and carries it through NUM_STAGES registered stages as a packed packet.
- Exposes every stage to the forwarding unit with a per-stage "result ready" flag, and drives registered register-file writeback.
- Adds valid tracking, stall and branch flush, which the first-generation pipe lacked.

Parameters:
- DATA_W, 128, result width.
- NUM_UNITS, 4, execution units feeding the pipe (FX1, FX2, SP, BYTE).
- UNIT_W, 3, unit_id width.
- NUM_STAGES, 7, delay stages before writeback; range 1..15.
- FLUSH_DEPTH, 1, youngest stages killed by flush; range 0..NUM_STAGES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  instruction issued this cycle.
- issue_unit_id  in  UNIT_W  selects one DATA_W slice of unit_results.
- unit_results  in  NUM_UNITS*DATA_W  combinational unit outputs; unit u occupies slice u, with slice 0 in the MSBs.
- issue_reg_dst  in  7  destination register.
- issue_latency  in  4  unit latency in stages.
- issue_reg_wr  in  1  instruction writes the register file.
- stall  in  1  freeze all stages.
- flush  in  1  kill younger instructions (branch mispredict).
- fwd_pkts  out  NUM_STAGES*PKT_W  stage k packet; stage 1 occupies the MSBs.
- fwd_ready  out  NUM_STAGES  bit k-1 high when stage k holds a valid packet with clamped latency <= k.
- wb_addr  out  7  writeback register.
- wb_data  out  DATA_W  writeback data.
- wb_en  out  1  writeback enable.

Behaviour:
- Packet layout, MSB first: {valid, unit_id, result, reg_dst, latency, reg_wr}. PKT_W = 1+UNIT_W+DATA_W+13.
- Stage 0 is combinational:
  - result = slice issue_unit_id of unit_results; zero if issue_unit_id >= NUM_UNITS.
  - valid = issue_valid.
  - latency clamp: 0 becomes 1; values > NUM_STAGES become NUM_STAGES. The clamped value is stored.
- Normal cycle (stall=0, flush=0): stage1 <= stage0, stage k <= stage k-1.
  - wb_* <= stage NUM_STAGES fields.
  - wb_en <= valid & reg_wr.
  - Issue-to-wb_en latency is NUM_STAGES+1 cycles.
- Stall=1:
  - All stages hold.
  - issue_* ignored; the issuer keeps them stable.
  - wb_en <= 0; wb_addr and wb_data hold.
  - This prevents a double write.
- Flush=1:
  - The stage-0 packet enters stage 1 with valid=0.
  - Stages 2..FLUSH_DEPTH receive their shifted packets with valid=0.
  - Older stages shift normally.
- Flush and stall together: stages 1..FLUSH_DEPTH clear valid in place, other stages hold, wb_en <= 0.
- Invalid packets: data fields propagate unchanged; only valid gates fwd_ready and wb_en.
- Reset: all stage registers, wb_addr, wb_data and wb_en are 0, effective immediately. Reset mid-operation discards all in-flight packets with no writeback.
- No backpressure on writeback: the register file always accepts.

Decomposition:
- spu_pipe_pkg holds:
  - PKT_W and field offset constants (VALID_BIT, UNIT_LSB/MSB, RES_LSB/MSB, DST, LAT, REGWR).
  - Function clamp_latency.
  - Unit ID constants FX1=0, FX2=1, SP=2, BYTE=3.
- One sub-module, spu_pipe_stage: a single PKT_W register with hold (stall), kill (clear valid) and async reset, instantiated NUM_STAGES times in a generate loop.

Test Plan:
- Reset, then issue unit 0 result 0x1234..., dst=5, lat=2, reg_wr=1 at cycle 0 -> fwd_ready[0]=0, fwd_ready[1]=1 at cycle 2, wb_en=1, wb_addr=5, wb_data=0x1234... at cycle 8 (NUM_STAGES=7), exactly one cycle.
- Back-to-back issues with unit_id 0,1,2,3 and distinct data -> four consecutive writebacks in order, each carrying its own unit's slice; unit_id 5 -> wb_data=0.
- Stall held 3 cycles while a packet sits in stage 7 -> wb_en=0 during the stall, then a single wb_en pulse the cycle after release; no duplicate write.
- Flush with FLUSH_DEPTH=2 while packets occupy stages 0,1,2,3 -> packets from stages 0 and 1 never write back; packets from stages 2 and 3 write back normally.
- Latency 0 and latency 12 -> stored latency 1 and 7; fwd_ready asserted from stage 1 and stage 7 respectively.
- Async rst asserted mid-stream with 5 packets in flight -> all fwd_ready and wb_en drop immediately; no writeback after rst release.
